// File: rtl/fmul_seq.sv
// -----------------------------------------------------------------------------
// fmul_seq -- iterative IEEE-754 multiplier (radix-2 shift-add mantissa loop)
//
// One operand pair per transaction over valid/ready. The normal path runs the
// mantissa loop for M+1 cycles and then normalises in one cycle. Special
// operands bypass the loop and reach DONE one cycle after accept.
// Subnormal inputs are treated as zero. Underflowing results are flushed to
// zero. No subnormal result is ever produced.
//
// Parameters
//   N : word width; 32 => 1/8/23 (bias 127), 64 => 1/11/52 (bias 1023)
//
// Configuration macro
//   FMUL_RNE_EN : when defined, NORM rounds to nearest, ties to even.
//                 When undefined, NORM truncates (round toward zero).
//
// Ports
//   clk        in   1  rising-edge clock
//   rst_n      in   1  asynchronous active-low reset
//   in_valid   in   1  operand pair valid
//   in_ready   out  1  high only in IDLE
//   a, b       in   N  IEEE operands, sampled on in_valid && in_ready
//   out_valid  out  1  result valid, held until consumed
//   out_ready  in   1  downstream accepts result
//   out        out  N  IEEE product, stable while out_valid
// -----------------------------------------------------------------------------
module fmul_seq #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out
);

  localparam int E    = (N == 64) ? 11 : 8;
  localparam int M    = (N == 64) ? 52 : 23;
  localparam int BIAS = (1 << (E - 1)) - 1;
  localparam int CW   = $clog2(M + 2);
  localparam logic signed [E+1:0] EXP_INF = (E+2)'((1 << E) - 1);

  typedef enum logic [1:0] {IDLE, CALC, NORM, DONE} state_t;

  state_t state, state_next;

  logic                  sign_r;
  logic [M:0]            ma, mb, acc;
  logic                  lo1;          // most recent bit shifted out of acc
`ifdef FMUL_RNE_EN
  logic                  lo2;          // bit shifted out one cycle earlier
  logic                  stk;          // OR of all older shifted-out bits
`endif
  logic [CW-1:0]         cnt;
  logic signed [E+1:0]   exp_r;
  logic [N-1:0]          out_r;

  // Operand decode
  logic [E-1:0] ea, eb;
  logic [M-1:0] fa, fb;
  logic         a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic         special, sign_in, accept;
  logic [N-1:0] special_out;

  assign ea     = a[N-2 -: E];
  assign eb     = b[N-2 -: E];
  assign fa     = a[M-1:0];
  assign fb     = b[M-1:0];
  assign a_nan  = (&ea) && (|fa);
  assign b_nan  = (&eb) && (|fb);
  assign a_inf  = (&ea) && !(|fa);
  assign b_inf  = (&eb) && !(|fb);
  assign a_zero = !(|ea);
  assign b_zero = !(|eb);
  assign special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
  assign sign_in = a[N-1] ^ b[N-1];
  assign accept  = in_valid && in_ready;

  // NOTE: every variable written in an always_comb gets a value on every path
  // (defaults first); otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    special_out = {sign_in, {(N-1){1'b0}}};
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
      special_out = {N{1'b1}};
    else if (a_inf || b_inf)
      special_out = {sign_in, {E{1'b1}}, {M{1'b0}}};
  end

  // One shift-add step: add the multiplicand when the multiplier LSB is set,
  // then shift the partial product right so that acc keeps the top M+1 bits.
  logic [M+1:0] sum;
  assign sum = {1'b0, acc} + {1'b0, (mb[0] ? ma : '0)};

  // Normalisation: acc holds P[2M+1:M+1], and P lies in [1,4).
  logic [M-1:0]        frac_n;
  logic signed [E+1:0] exp_n;
  logic [N-1:0]        norm_out;
`ifdef FMUL_RNE_EN
  logic                guard, sticky, carry;
`endif

  always_comb begin
    frac_n = acc[M] ? acc[M-1:0] : {acc[M-2:0], lo1};
    exp_n  = exp_r + {{(E+1){1'b0}}, acc[M]};
`ifdef FMUL_RNE_EN
    carry  = 1'b0;
    guard  = acc[M] ? lo1 : lo2;
    sticky = acc[M] ? (lo2 | stk) : stk;
    if (guard && (sticky || frac_n[0])) begin
      // A carry out of the fraction means the mantissa rounded up to 2.0.
      {carry, frac_n} = {1'b0, frac_n} + (M+1)'(1);
      exp_n = exp_n + {{(E+1){1'b0}}, carry};
    end
`endif
    if (exp_n >= EXP_INF)
      norm_out = {sign_r, {E{1'b1}}, {M{1'b0}}};
    else if (exp_n[E+1] || (exp_n == '0))
      norm_out = {sign_r, {(N-1){1'b0}}};
    else
      norm_out = {sign_r, exp_n[E-1:0], frac_n};
  end

  // NOTE: sequential state uses non-blocking assignments so that every flop
  // samples the values from before the clock edge, whatever the statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = special ? DONE : CALC;
      end
      CALC: if (cnt == CW'(1)) state_next = NORM;
      NORM: state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the datapath registers are reset too, so that an aborted transaction
  // leaves no stale operands behind and out reads zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_r <= 1'b0;
      ma     <= '0;
      mb     <= '0;
      acc    <= '0;
      lo1    <= 1'b0;
`ifdef FMUL_RNE_EN
      lo2    <= 1'b0;
      stk    <= 1'b0;
`endif
      cnt    <= '0;
      exp_r  <= '0;
      out_r  <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          sign_r <= sign_in;
          ma     <= {1'b1, fa};
          mb     <= {1'b1, fb};
          acc    <= '0;
          lo1    <= 1'b0;
`ifdef FMUL_RNE_EN
          lo2    <= 1'b0;
          stk    <= 1'b0;
`endif
          cnt    <= CW'(M + 1);
          exp_r  <= (E+2)'(ea) + (E+2)'(eb) - (E+2)'(BIAS);
          if (special) out_r <= special_out;
        end
        CALC: begin
          acc <= sum[M+1:1];
          lo1 <= sum[0];
`ifdef FMUL_RNE_EN
          lo2 <= lo1;
          stk <= stk | lo2;
`endif
          mb  <= mb >> 1;
          cnt <= cnt - CW'(1);
        end
        NORM:    out_r <= norm_out;
        default: ;
      endcase
    end
  end

  assign out = out_r;

endmodule

// File: tb/tb_fmul_seq.sv
// -----------------------------------------------------------------------------
// tb_fmul_seq -- directed testbench for fmul_seq (N = 32).
// Inputs are driven and outputs sampled on the falling clock edge. Latency is
// the number of falling edges from the accept edge up to the first one at
// which out_valid is seen.
// -----------------------------------------------------------------------------
module tb_fmul_seq;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a, b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fmul_seq #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Present an operand pair and let the next rising edge accept it.
  task automatic start(input string tag, input logic [N-1:0] av, input logic [N-1:0] bv);
    @(negedge clk);
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    check({tag, "/in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
  endtask

  // Count cycles until out_valid (bounded), then compare latency and result.
  task automatic wait_result(input string tag, input int exp_lat, input logic [N-1:0] exp_out);
    int lat;
    lat = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 200);
    check({tag, "/latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "/out"}, 64'(out), 64'(exp_out));
  endtask

  // Consume the result; in_ready must be high in the cycle after the handshake.
  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "/out_valid_low"}, 64'(out_valid), 64'd0);
    check({tag, "/in_ready_back"}, 64'(in_ready), 64'd1);
  endtask

  task automatic run_txn(input string tag, input logic [N-1:0] av, input logic [N-1:0] bv,
                         input int exp_lat, input logic [N-1:0] exp_out);
    start(tag, av, bv);
    wait_result(tag, exp_lat, exp_out);
    consume(tag);
  endtask

  initial begin
    logic [N-1:0] rne_exp;
`ifdef FMUL_RNE_EN
    rne_exp = 32'h4010_0002;
`else
    rne_exp = 32'h4010_0001;
`endif

    // Reset state
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    #12;
    check("reset/in_ready", 64'(in_ready), 64'd1);
    check("reset/out_valid", 64'(out_valid), 64'd0);
    check("reset/out", 64'(out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Normal path
    run_txn("t1_2x3", 32'h4000_0000, 32'h4040_0000, 26, 32'h40C0_0000);
    run_txn("t2_1p5sq", 32'h3FC0_0000, 32'h3FC0_0000, 26, 32'h4010_0000);
    run_txn("t2_round", 32'h3FC0_0001, 32'h3FC0_0001, 26, rne_exp);
    run_txn("neg_1p5xm2", 32'h3FC0_0000, 32'hC000_0000, 26, 32'hC040_0000);

    // Special operands: one-cycle path
    run_txn("t3_m1xinf", 32'hBF80_0000, 32'h7F80_0000, 1, 32'hFF80_0000);
    run_txn("t3_0xinf", 32'h0000_0000, 32'h7F80_0000, 1, 32'hFFFF_FFFF);
    run_txn("nan_x1", 32'h7FC0_0000, 32'h3F80_0000, 1, 32'hFFFF_FFFF);
    run_txn("subn_xm2", 32'h0000_0001, 32'hC000_0000, 1, 32'h8000_0000);

    // Range limits
    run_txn("t4_ovf", 32'h7F00_0000, 32'h7F00_0000, 26, 32'h7F80_0000);
    run_txn("t4_unf", 32'h0080_0000, 32'h0080_0000, 26, 32'h0000_0000);

    // Back-pressure: result held for 10 cycles while a new request is ignored
    start("t5", 32'h4000_0000, 32'h4040_0000);
    wait_result("t5", 26, 32'h40C0_0000);
    for (int i = 0; i < 10; i++) begin
      a        = 32'h3FC0_0000;
      b        = 32'h3FC0_0000;
      in_valid = 1'b1;
      @(negedge clk);
      check("t5/hold_out", 64'(out), 64'h40C0_0000);
      check("t5/hold_valid", 64'(out_valid), 64'd1);
      check("t5/hold_in_ready", 64'(in_ready), 64'd0);
    end
    // Simultaneous out_ready and in_valid in DONE: only the result is consumed.
    consume("t5");
    in_valid = 1'b0;
    run_txn("t5_after", 32'h3FC0_0000, 32'hC000_0000, 26, 32'hC040_0000);

    // Reset in the fifth CALC cycle aborts the transaction
    start("t6", 32'h3FC0_0000, 32'h3FC0_0000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("t6/out_valid", 64'(out_valid), 64'd0);
    check("t6/in_ready", 64'(in_ready), 64'd1);
    check("t6/out", 64'(out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6/no_result", 64'(out_valid), 64'd0);
    run_txn("t6_2x3", 32'h4000_0000, 32'h4040_0000, 26, 32'h40C0_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
